// File: rtl/sm83_sequencer_if.sv
// Handshake bundle between the SM83 instruction decoder/control and the T/M-cycle sequencer.
// The master drives the decode results and the enables; the slave (sequencer) returns the timing.
interface sm83_sequencer_if;
    logic       ce;
    logic [2:0] mcyc_base;
    logic [2:0] mcyc_taken;
    logic       is_cond;
    logic       cond_true;
    logic       is_prefix_cb;
    logic       is_halt;
    logic       is_stop;
    logic       is_alu_class;
    logic       irq;
    logic       ime;
    logic       wake;

    logic [1:0] t_cycle;
    logic [2:0] m_cycle;
    logic       last_m;
    logic       opcode_ld;
    logic       pc_inc;
    logic       bank_cb;
    logic       in_halt;
    logic       in_alu;
    logic       int_active;
    logic       int_ack;
    logic       stopped;

    modport master (
        output ce, mcyc_base, mcyc_taken, is_cond, cond_true, is_prefix_cb,
               is_halt, is_stop, is_alu_class, irq, ime, wake,
        input  t_cycle, m_cycle, last_m, opcode_ld, pc_inc, bank_cb,
               in_halt, in_alu, int_active, int_ack, stopped
    );

    modport slave (
        input  ce, mcyc_base, mcyc_taken, is_cond, cond_true, is_prefix_cb,
               is_halt, is_stop, is_alu_class, irq, ime, wake,
        output t_cycle, m_cycle, last_m, opcode_ld, pc_inc, bank_cb,
               in_halt, in_alu, int_active, int_ack, stopped
    );
endinterface

// File: rtl/sm83_sequencer.sv
// SM83 T-cycle/M-cycle sequencer with RUN/HALT/STOP/INT states and interrupt dispatch.
// Optional: define SM83_HALT_BUG_EN to reproduce the HALT bug (skipped PC increment).
module sm83_sequencer (
    input  logic            clk,
    input  logic            reset,
    sm83_sequencer_if.slave bus
);
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STOP, ST_INT} state_t;

`ifdef SM83_HALT_BUG_EN
    localparam logic HALT_BUG_PC_INC = 1'b0;
`else
    localparam logic HALT_BUG_PC_INC = 1'b1;
`endif

    state_t     state_q;
    logic [1:0] t_q;
    logic [2:0] m_q;
    logic       boot_q;
    logic       bank_cb_q;
    logic       opcode_ld_q;
    logic       pc_inc_q;
    logic       int_ack_q;

    logic [2:0] len;
    logic [2:0] len_m1;
    logic       last_m;
    logic       take_int;
    logic       halt_irq_pending;

    always_comb begin
        len    = (bus.is_cond && bus.cond_true) ? bus.mcyc_taken : bus.mcyc_base;
        len_m1 = (len == 3'd0) ? 3'd0 : len - 3'd1;
    end

    assign last_m           = (m_q == len_m1);
    assign take_int         = bus.irq && bus.ime && !bus.is_prefix_cb && !bank_cb_q;
    // HALT with IME clear and an interrupt already pending never sleeps.
    assign halt_irq_pending = bus.is_halt && !bus.ime && bus.irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            t_q         <= 2'd0;
            m_q         <= 3'd0;
            boot_q      <= 1'b1;
            bank_cb_q   <= 1'b0;
            opcode_ld_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            int_ack_q   <= 1'b0;
        end else if (bus.ce) begin
            opcode_ld_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            int_ack_q   <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    t_q <= t_q + 2'd1;
                    if (t_q == 2'd3) begin
                        if (boot_q) begin
                            // First M-cycle after reset only fetches; PC already points at the opcode.
                            boot_q      <= 1'b0;
                            m_q         <= 3'd0;
                            opcode_ld_q <= 1'b1;
                            bank_cb_q   <= 1'b0;
                        end else if (last_m) begin
                            m_q <= 3'd0;
                            if (take_int) begin
                                state_q <= ST_INT;
                            end else if (bus.is_halt && !halt_irq_pending) begin
                                state_q <= ST_HALT;
                            end else if (bus.is_stop && !bus.is_halt) begin
                                state_q <= ST_STOP;
                            end else begin
                                opcode_ld_q <= 1'b1;
                                pc_inc_q    <= halt_irq_pending ? HALT_BUG_PC_INC : 1'b1;
                                bank_cb_q   <= bus.is_prefix_cb;
                            end
                        end else begin
                            m_q <= m_q + 3'd1;
                        end
                    end
                end
                ST_HALT: begin
                    t_q <= t_q + 2'd1;
                    if (t_q == 2'd3 && bus.irq) begin
                        if (bus.ime) begin
                            state_q <= ST_INT;
                        end else begin
                            state_q     <= ST_RUN;
                            opcode_ld_q <= 1'b1;
                            pc_inc_q    <= 1'b1;
                            bank_cb_q   <= 1'b0;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.wake) begin
                        state_q <= ST_RUN;
                        t_q     <= 2'd0;
                        m_q     <= 3'd0;
                    end
                end
                ST_INT: begin
                    t_q <= t_q + 2'd1;
                    if (t_q == 2'd3) begin
                        if (m_q == 3'd3) begin
                            int_ack_q <= 1'b1;
                        end
                        if (m_q == 3'd4) begin
                            state_q     <= ST_RUN;
                            m_q         <= 3'd0;
                            opcode_ld_q <= 1'b1;
                            pc_inc_q    <= 1'b1;
                            bank_cb_q   <= 1'b0;
                        end else begin
                            m_q <= m_q + 3'd1;
                        end
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.t_cycle    = t_q;
    assign bus.m_cycle    = m_q;
    assign bus.last_m     = last_m;
    assign bus.opcode_ld  = opcode_ld_q;
    assign bus.pc_inc     = pc_inc_q;
    assign bus.bank_cb    = bank_cb_q;
    assign bus.in_halt    = (state_q == ST_HALT);
    assign bus.in_alu     = bus.is_alu_class && last_m && (state_q == ST_RUN);
    assign bus.int_active = (state_q == ST_INT);
    assign bus.int_ack    = int_ack_q;
    assign bus.stopped    = (state_q == ST_STOP);
endmodule

// File: tb/tb_sm83_sequencer.sv
// Directed, table-driven bench for sm83_sequencer: instruction lengths, CB/INT, HALT, STOP, reset.
module tb_sm83_sequencer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    sm83_sequencer_if bus ();

    sm83_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0] base;
        logic [2:0] taken;
        bit         cond;
        bit         ctrue;
        bit         alu;
        bit         gap;
        int         exp_ce;
        int         exp_alu;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ce-cycles until opcode_ld is seen; counts ce edges and in_alu samples before it.
    task automatic run_instr(input bit gap, output int n, output int alu_n,
                             output bit seen_halt, output bit seen_int);
        logic [1:0] t0;
        n = 0; alu_n = 0; seen_halt = 1'b0; seen_int = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (gap) begin
                t0 = bus.t_cycle;
                bus.ce = 1'b0;
                tick();
                check("ce0_hold_t", int'(bus.t_cycle), int'(t0));
                bus.ce = 1'b1;
            end
            tick();
            n++;
            if (bus.in_halt)    seen_halt = 1'b1;
            if (bus.int_active) seen_int  = 1'b1;
            if (bus.opcode_ld) begin
                $display("instr: ce=%0d pc_inc=%0d bank_cb=%0d alu=%0d", n, bus.pc_inc, bus.bank_cb, alu_n);
                return;
            end
            if (bus.in_alu) alu_n++;
        end
        check("opcode_ld_timeout", 0, 1);
    endtask

    task automatic set_decode(input logic [2:0] base);
        bus.mcyc_base = base; bus.mcyc_taken = 3'd0; bus.is_cond = 1'b0; bus.cond_true = 1'b0;
        bus.is_prefix_cb = 1'b0; bus.is_halt = 1'b0; bus.is_stop = 1'b0; bus.is_alu_class = 1'b0;
    endtask

    initial begin
        int n, alu_n, t_ack, t_ld, t_ent;
        bit sh, si, changed, acked;
        logic [1:0] t_frozen;
        n_cmp = 0; n_bad = 0;
        vecs[0] = '{3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0,  4, 3};
        vecs[1] = '{3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0,  8, 0};
        vecs[2] = '{3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 12, 4};
        vecs[3] = '{3'd3, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0};
        vecs[4] = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0,  4, 3};
        vecs[5] = '{3'd5, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0,  4, 0};
        vecs[6] = '{3'd4, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 24, 4};
        vecs[7] = '{3'd6, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 24, 0};

        bus.ce = 1'b1; bus.irq = 1'b0; bus.ime = 1'b0; bus.wake = 1'b0;
        set_decode(3'd1);
        reset = 1'b1;
        repeat (3) tick();
        check("rst_t_cycle",    int'(bus.t_cycle), 0);
        check("rst_m_cycle",    int'(bus.m_cycle), 0);
        check("rst_bank_cb",    int'(bus.bank_cb), 0);
        check("rst_opcode_ld",  int'(bus.opcode_ld), 0);
        check("rst_pc_inc",     int'(bus.pc_inc), 0);
        check("rst_flags",      int'({bus.in_halt, bus.int_active, bus.int_ack, bus.stopped}), 0);
        reset = 1'b0;

        run_instr(1'b0, n, alu_n, sh, si);
        check("boot_ce", n, 4);
        check("boot_pc_inc", int'(bus.pc_inc), 0);
        check("boot_m_cycle", int'(bus.m_cycle), 0);
        run_instr(1'b0, n, alu_n, sh, si);
        check("second_ce", n, 4);
        check("second_pc_inc", int'(bus.pc_inc), 1);

        for (int i = 0; i < 8; i++) begin
            set_decode(vecs[i].base);
            bus.mcyc_taken = vecs[i].taken; bus.is_cond = vecs[i].cond;
            bus.cond_true = vecs[i].ctrue; bus.is_alu_class = vecs[i].alu;
            run_instr(vecs[i].gap, n, alu_n, sh, si);
            check($sformatf("vec%0d_ce", i), n, vecs[i].exp_ce);
            check($sformatf("vec%0d_pc_inc", i), int'(bus.pc_inc), 1);
            check($sformatf("vec%0d_in_alu", i), alu_n, vecs[i].exp_alu);
        end

        // CB prefix with an interrupt pending: dispatch waits for the CB op and its successor's end.
        set_decode(3'd1); bus.is_prefix_cb = 1'b1; bus.irq = 1'b1; bus.ime = 1'b1;
        run_instr(1'b0, n, alu_n, sh, si);
        check("cb_prefix_ce", n, 4);
        check("cb_bank_set", int'(bus.bank_cb), 1);
        set_decode(3'd2);
        run_instr(1'b0, n, alu_n, sh, si);
        check("cb_op_ce", n, 8);
        check("cb_op_no_int", int'(si), 0);
        check("cb_bank_clear", int'(bus.bank_cb), 0);
        set_decode(3'd1);
        t_ent = -1; t_ack = -1; t_ld = -1; n = 0;
        for (int k = 0; k < 60 && t_ld < 0; k++) begin
            tick(); n++;
            if (t_ent < 0 && bus.int_active) begin
                t_ent = n;
                check("int_entry_no_ld", int'(bus.opcode_ld), 0);
            end
            if (bus.int_ack) begin t_ack = n; bus.irq = 1'b0; bus.ime = 1'b0; end
            if (bus.opcode_ld) t_ld = n;
        end
        check("int_entry_ce", t_ent, 4);
        check("int_ack_ce", t_ack - t_ent, 16);
        check("int_len_ce", t_ld - t_ent, 20);
        check("int_ret_pc_inc", int'(bus.pc_inc), 1);
        check("int_ret_state", int'({bus.int_active, bus.m_cycle}), 0);
        $display("int: entry=%0d ack=%0d ld=%0d", t_ent, t_ack, t_ld);

        // HALT with IME=0, irq arriving 10 ce after entry.
        set_decode(3'd1); bus.is_halt = 1'b1;
        repeat (4) tick();
        check("halt_in_halt", int'(bus.in_halt), 1);
        check("halt_no_ld", int'({bus.opcode_ld, bus.pc_inc}), 0);
        check("halt_m_cycle", int'(bus.m_cycle), 0);
        changed = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!bus.in_halt || bus.opcode_ld) changed = 1'b1;
        end
        check("halt_held", int'(changed), 0);
        bus.irq = 1'b1;
        tick();
        check("halt_wait_t3", int'({bus.in_halt, bus.opcode_ld}), 2);
        tick();
        check("halt_exit", int'({bus.in_halt, bus.opcode_ld}), 1);
        $display("halt: exit in_halt=%0d opcode_ld=%0d", bus.in_halt, bus.opcode_ld);

        // HALT with IME=0 and irq already pending.
        set_decode(3'd1); bus.is_halt = 1'b1;
        run_instr(1'b0, n, alu_n, sh, si);
        check("haltbug_ce", n, 4);
        check("haltbug_no_halt", int'(sh), 0);
`ifdef SM83_HALT_BUG_EN
        check("haltbug_pc_inc", int'(bus.pc_inc), 0);
`else
        check("haltbug_pc_inc", int'(bus.pc_inc), 1);
`endif
        bus.irq = 1'b0;

        // STOP: frozen for 100 ce, wake with ce=0 ignored, wake with ce=1 resumes.
        set_decode(3'd1); bus.is_stop = 1'b1;
        repeat (4) tick();
        check("stop_stopped", int'({bus.stopped, bus.opcode_ld}), 2);
        t_frozen = bus.t_cycle;
        changed = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.t_cycle != t_frozen || !bus.stopped) changed = 1'b1;
        end
        check("stop_frozen", int'(changed), 0);
        bus.wake = 1'b1; bus.ce = 1'b0;
        tick();
        check("stop_wake_ce0", int'(bus.stopped), 1);
        bus.ce = 1'b1;
        tick();
        check("stop_wake", int'({bus.stopped, bus.opcode_ld}), 0);
        check("stop_wake_t", int'(bus.t_cycle), 0);
        check("stop_wake_m", int'(bus.m_cycle), 0);
        bus.wake = 1'b0;
        set_decode(3'd1);
        run_instr(1'b0, n, alu_n, sh, si);
        check("stop_resume_ce", n, 4);

        // Reset mid-INT (m_cycle 2) aborts at once with no later int_ack.
        bus.irq = 1'b1; bus.ime = 1'b1;
        repeat (4) tick();
        check("rint_entry", int'(bus.int_active), 1);
        repeat (10) tick();
        check("rint_m_cycle", int'(bus.m_cycle), 2);
        #2 reset = 1'b1;
        #1;
        check("rint_abort", int'({bus.int_active, bus.m_cycle, bus.t_cycle}), 0);
        acked = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.int_ack) acked = 1'b1;
        end
        reset = 1'b0;
        run_instr(1'b0, n, alu_n, sh, si);
        check("rint_no_ack", int'(acked), 0);
        check("rint_boot_ce", n, 4);
        check("rint_boot_pc_inc", int'(bus.pc_inc), 0);
        check("rint_boot_no_int", int'(si), 0);
        bus.irq = 1'b0; bus.ime = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
